// File: rtl/menu_controller_pkg.sv
// Shared encodings for the configuration-menu sequencer and the datapath that
// decodes menu_sel.
package menu_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_MODO   = 3'd2,
      ST_BPM    = 3'd3,
      ST_TOM    = 3'd4,
      ST_MUSICA = 3'd5,
      ST_ERRO   = 3'd6,
      ST_DONE   = 3'd7
   } state_e;

   localparam logic [2:0] MENU_SEL_MODO   = 3'b000;
   localparam logic [2:0] MENU_SEL_BPM    = 3'b001;
   localparam logic [2:0] MENU_SEL_TOM    = 3'b010;
   localparam logic [2:0] MENU_SEL_MUSICA = 3'b011;
   localparam logic [2:0] MENU_SEL_ERRO   = 3'b100;

   // True for the five states in which the user is choosing a value.
   function automatic logic in_select(state_e s);
      return (s == ST_MODO) || (s == ST_BPM) || (s == ST_TOM) ||
             (s == ST_MUSICA) || (s == ST_ERRO);
   endfunction

   function automatic logic [2:0] sel_code(state_e s);
      logic [2:0] code;
      code = MENU_SEL_MODO;
      case (s)
         ST_BPM:    code = MENU_SEL_BPM;
         ST_TOM:    code = MENU_SEL_TOM;
         ST_MUSICA: code = MENU_SEL_MUSICA;
         ST_ERRO:   code = MENU_SEL_ERRO;
         default:   code = MENU_SEL_MODO;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/menu_controller_edge_detector.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level is seen high.
module edge_detector (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic pulse_o
);

   logic prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_i;
      end
   end

   assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/menu_controller.sv
// Configuration-menu sequencer: steps through mode, BPM, tone, song and error
// limit, strobes the display on every change and abandons the menu when idle.
module menu_controller
   import menu_controller_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       enter_pressed,
   input  logic       back_pressed,
   input  logic       arrow_pressed,
   input  logic       skip_musica,
   input  logic       restart,
   output logic [2:0] menu_sel,
   output logic       load_initial,
   output logic       nav_enable,
   output logic       arduino_update,
   output logic       config_done,
   output logic       timeout
);

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             rst_hi;
   logic             start_p, enter_p, back_p, arrow_p, restart_p;
   logic             activity, expire;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             entered_q, entered_d;
   logic             au_q, au_d;
   logic [2:0]       menu_sel_q;
   logic             load_q, nav_q, done_q, timeout_q;

   assign rst_hi = ~reset;

   edge_detector u_start_ed (
      .clk_i(clock), .rst_i(rst_hi), .level_i(start), .pulse_o(start_p)
   );
   edge_detector u_enter_ed (
      .clk_i(clock), .rst_i(rst_hi), .level_i(enter_pressed), .pulse_o(enter_p)
   );
   edge_detector u_back_ed (
      .clk_i(clock), .rst_i(rst_hi), .level_i(back_pressed), .pulse_o(back_p)
   );
   edge_detector u_arrow_ed (
      .clk_i(clock), .rst_i(rst_hi), .level_i(arrow_pressed), .pulse_o(arrow_p)
   );
   edge_detector u_restart_ed (
      .clk_i(clock), .rst_i(rst_hi), .level_i(restart), .pulse_o(restart_p)
   );

   // Any key activity in a select state cancels a pending expiry.
   assign activity = enter_p | back_p | arrow_p;
   assign expire   = in_select(state_q) && !activity && (cnt_q == CNT_LIMIT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_p) state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_MODO;
         ST_MODO: begin
            if (back_p)       state_d = ST_IDLE;
            else if (enter_p) state_d = ST_BPM;
         end
         ST_BPM: begin
            if (back_p)       state_d = ST_MODO;
            else if (enter_p) state_d = ST_TOM;
         end
         ST_TOM: begin
            if (back_p)       state_d = ST_BPM;
            else if (enter_p) state_d = skip_musica ? ST_ERRO : ST_MUSICA;
         end
         ST_MUSICA: begin
            if (back_p)       state_d = ST_TOM;
            else if (enter_p) state_d = ST_ERRO;
         end
         ST_ERRO: begin
            if (back_p)       state_d = skip_musica ? ST_TOM : ST_MUSICA;
            else if (enter_p) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (restart_p)    state_d = ST_IDLE;
            else if (back_p)  state_d = ST_ERRO;
         end
         default:             state_d = ST_IDLE;
      endcase
      if (expire) state_d = ST_IDLE;
   end

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!in_select(state_q) || (state_d != state_q) || activity) cnt_d = '0;
   end

   // The display strobe trails the state entry by one cycle so the datapath has
   // already switched menu_sel when the display resamples.
   assign entered_d = in_select(state_d) && (state_d != state_q);
   assign au_d      = in_select(state_d) && (entered_q || (arrow_p && in_select(state_q)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         entered_q  <= 1'b0;
         au_q       <= 1'b0;
         menu_sel_q <= MENU_SEL_MODO;
         load_q     <= 1'b0;
         nav_q      <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         entered_q  <= entered_d;
         au_q       <= au_d;
         menu_sel_q <= sel_code(state_d);
         load_q     <= (state_d == ST_LOAD);
         nav_q      <= in_select(state_d);
         done_q     <= (state_d == ST_DONE);
         timeout_q  <= expire;
      end
   end

   assign menu_sel       = menu_sel_q;
   assign load_initial   = load_q;
   assign nav_enable     = nav_q;
   assign arduino_update = au_q;
   assign config_done    = done_q;
   assign timeout        = timeout_q;

endmodule

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: directed walk-throughs plus randomized key traffic
// compared every cycle against a menu-position reference model.
module tb_menu_controller;

   localparam int TO = 8;
   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_MENU = 2;
   localparam int M_DONE = 3;

   logic       clock = 1'b0;
   logic       reset, start, enter_pressed, back_pressed, arrow_pressed, skip_musica, restart;
   logic [2:0] menu_sel;
   logic       load_initial, nav_enable, arduino_update, config_done, timeout;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: mode, menu item index 0..4, idle cycle count
   int m_mode, m_item, m_idle;
   bit m_entered, m_au, m_to;
   bit pv_start, pv_enter, pv_back, pv_arrow, pv_restart;

   menu_controller #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .start(start), .enter_pressed(enter_pressed),
      .back_pressed(back_pressed), .arrow_pressed(arrow_pressed),
      .skip_musica(skip_musica), .restart(restart), .menu_sel(menu_sel),
      .load_initial(load_initial), .nav_enable(nav_enable),
      .arduino_update(arduino_update), .config_done(config_done), .timeout(timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_item = 0; m_idle = 0;
      m_entered = 0; m_au = 0; m_to = 0;
      pv_start = 0; pv_enter = 0; pv_back = 0; pv_arrow = 0; pv_restart = 0;
   endtask

   task automatic model_step();
      bit p_st, p_en, p_bk, p_ar, p_rs, was_menu, now_menu, changed;
      int old_mode, old_item;
      p_st = start & ~pv_start;
      p_en = enter_pressed & ~pv_enter;
      p_bk = back_pressed & ~pv_back;
      p_ar = arrow_pressed & ~pv_arrow;
      p_rs = restart & ~pv_restart;
      pv_start = start; pv_enter = enter_pressed; pv_back = back_pressed;
      pv_arrow = arrow_pressed; pv_restart = restart;
      old_mode = m_mode; old_item = m_item;
      was_menu = (m_mode == M_MENU);
      m_to = 0;
      case (m_mode)
         M_IDLE: if (p_st) m_mode = M_LOAD;
         M_LOAD: begin m_mode = M_MENU; m_item = 0; end
         M_MENU: begin
            if (p_bk) begin
               if (m_item == 0)      m_mode = M_IDLE;
               else if (m_item == 4) m_item = skip_musica ? 2 : 3;
               else                  m_item = m_item - 1;
            end else if (p_en) begin
               if (m_item == 4)                    m_mode = M_DONE;
               else if (m_item == 2 && skip_musica) m_item = 4;
               else                                m_item = m_item + 1;
            end else if (!p_ar && m_idle == TO - 1) begin
               m_mode = M_IDLE;
               m_to = 1;
            end
         end
         default: begin
            if (p_rs) m_mode = M_IDLE;
            else if (p_bk) begin m_mode = M_MENU; m_item = 4; end
         end
      endcase
      now_menu  = (m_mode == M_MENU);
      changed   = (m_mode != old_mode) || (m_item != old_item);
      m_au      = now_menu && (m_entered || (p_ar && was_menu));
      m_entered = now_menu && changed;
      if (!was_menu || changed || p_en || p_bk || p_ar) m_idle = 0;
      else m_idle = m_idle + 1;
   endtask

   task automatic check_outputs(input string tag);
      logic [2:0] e_sel;
      e_sel = (m_mode == M_MENU) ? 3'(m_item) : 3'd0;
      check({tag, ".menu_sel"},  {5'd0, menu_sel},       {5'd0, e_sel});
      check({tag, ".load"},      {7'd0, load_initial},   {7'd0, m_mode == M_LOAD});
      check({tag, ".nav"},       {7'd0, nav_enable},     {7'd0, m_mode == M_MENU});
      check({tag, ".update"},    {7'd0, arduino_update}, {7'd0, m_au});
      check({tag, ".done"},      {7'd0, config_done},    {7'd0, m_mode == M_DONE});
      check({tag, ".timeout"},   {7'd0, timeout},        {7'd0, m_to});
   endtask

   // one clock: model advances at the rising edge, outputs compared at the falling edge
   task automatic tick(input string tag);
      @(posedge clock);
      if (reset) model_step();
      @(negedge clock);
      check_outputs(tag);
   endtask

   task automatic set_keys(input bit st, input bit en, input bit bk, input bit ar, input bit rs);
      start = st; enter_pressed = en; back_pressed = bk; arrow_pressed = ar; restart = rs;
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b0;
      model_reset();
      #1 check_outputs(tag);
   endtask

   int quiet;

   initial begin
      reset = 1'b0;
      skip_musica = 1'b0;
      set_keys(0, 0, 0, 0, 0);
      model_reset();
      #2 check_outputs("reset");
      repeat (2) tick("reset_hold");
      reset = 1'b1;

      set_keys(1, 0, 0, 0, 0); tick("start");
      check("start_load", {7'd0, load_initial}, 8'd1);
      set_keys(0, 0, 0, 0, 0); tick("load");
      check("load_sel", {5'd0, menu_sel}, 8'd0);
      check("load_nav", {7'd0, nav_enable}, 8'd1);
      check("load_one_cycle", {7'd0, load_initial}, 8'd0);
      tick("modo_entry");
      check("entry_update", {7'd0, arduino_update}, 8'd1);

      for (int i = 1; i <= 4; i++) begin
         set_keys(0, 1, 0, 0, 0); tick("walk");
         check("walk_sel", {5'd0, menu_sel}, 8'(i));
         set_keys(0, 0, 0, 0, 0); tick("walk_gap");
      end
      set_keys(0, 1, 0, 0, 0); tick("to_done");
      check("done_level", {7'd0, config_done}, 8'd1);
      check("done_sel", {5'd0, menu_sel}, 8'd0);
      set_keys(0, 0, 0, 0, 0); tick("done_gap");
      set_keys(0, 1, 0, 0, 0); tick("done_enter_ignored");
      check("done_hold", {7'd0, config_done}, 8'd1);
      set_keys(0, 0, 0, 0, 1); tick("restart");
      check("restart_idle", {7'd0, config_done}, 8'd0);
      set_keys(0, 0, 0, 0, 0); tick("idle_gap");

      // free-play path skips the song selection in both directions
      set_keys(1, 0, 0, 0, 0); tick("s_start");
      set_keys(0, 0, 0, 0, 0); tick("s_load");
      set_keys(0, 1, 0, 0, 0); tick("s_bpm");
      set_keys(0, 0, 0, 0, 0); tick("s_gap");
      set_keys(0, 1, 0, 0, 0); tick("s_tom");
      set_keys(0, 0, 0, 0, 0); tick("s_gap");
      skip_musica = 1'b1;
      set_keys(0, 1, 0, 0, 0); tick("s_skip_fwd");
      check("skip_fwd_sel", {5'd0, menu_sel}, 8'd4);
      set_keys(0, 0, 0, 0, 0); tick("s_gap");
      set_keys(0, 0, 1, 0, 0); tick("s_skip_back");
      check("skip_back_sel", {5'd0, menu_sel}, 8'd2);
      set_keys(0, 0, 0, 0, 0); tick("s_gap");
      skip_musica = 1'b0;
      set_keys(0, 0, 1, 0, 0); tick("s_back_bpm");
      set_keys(0, 0, 0, 0, 0); tick("s_gap");
      set_keys(0, 1, 1, 0, 0); tick("both_keys");
      check("back_priority", {5'd0, menu_sel}, 8'd0);
      set_keys(0, 0, 0, 0, 0); tick("s_gap");

      // plain expiry in S_BPM
      set_keys(0, 1, 0, 0, 0); tick("t_bpm");
      set_keys(0, 0, 0, 0, 0);
      for (int k = 1; k <= 7; k++) begin
         tick("t_wait");
         check("timeout_early", {7'd0, timeout}, 8'd0);
      end
      tick("t_fire");
      check("timeout_fire", {7'd0, timeout}, 8'd1);
      check("timeout_nav", {7'd0, nav_enable}, 8'd0);
      tick("t_after");
      check("timeout_one_shot", {7'd0, timeout}, 8'd0);

      // arrow at the fifth cycle restarts the idle count
      set_keys(1, 0, 0, 0, 0); tick("a_start");
      set_keys(0, 0, 0, 0, 0); tick("a_load");
      set_keys(0, 1, 0, 0, 0); tick("a_bpm");
      set_keys(0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) tick("a_wait");
      set_keys(0, 0, 0, 1, 0); tick("a_arrow");
      check("arrow_update", {7'd0, arduino_update}, 8'd1);
      set_keys(0, 0, 0, 0, 0);
      for (int k = 1; k <= 7; k++) begin
         tick("a_wait2");
         check("arrow_delay", {7'd0, timeout}, 8'd0);
      end
      tick("a_fire");
      check("arrow_fire", {7'd0, timeout}, 8'd1);

      // enter on the expiry cycle wins over the timeout
      set_keys(1, 0, 0, 0, 0); tick("c_start");
      set_keys(0, 0, 0, 0, 0); tick("c_load");
      set_keys(0, 1, 0, 0, 0); tick("c_bpm");
      set_keys(0, 0, 0, 0, 0);
      for (int k = 1; k <= 7; k++) tick("c_wait");
      set_keys(0, 1, 0, 0, 0); tick("c_enter");
      check("collide_no_timeout", {7'd0, timeout}, 8'd0);
      check("collide_sel", {5'd0, menu_sel}, 8'd2);
      set_keys(0, 0, 0, 0, 0); tick("c_gap");
      set_keys(0, 1, 0, 0, 0); tick("c_musica");
      set_keys(0, 0, 0, 0, 0);

      // asynchronous reset in S_MUSICA, then enter held across release
      async_reset("r_async");
      check("async_nav", {7'd0, nav_enable}, 8'd0);
      tick("r_hold");
      set_keys(0, 1, 0, 0, 0);
      reset = 1'b1;
      tick("r_release");
      check("held_enter_idle", {7'd0, nav_enable}, 8'd0);
      tick("r_release2");
      check("held_enter_still_idle", {5'd0, menu_sel, load_initial, nav_enable}, 8'd0);
      set_keys(0, 0, 0, 0, 0); tick("r_gap");

      quiet = 0;
      for (int c = 0; c < 4000; c++) begin
         if (quiet > 0) begin
            quiet--;
            set_keys(0, 0, 0, 0, 0);
         end else begin
            if ($urandom_range(0, 99) < 4) quiet = int'($urandom_range(5, 12));
            set_keys($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 7) == 0);
            skip_musica = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rnd_reset");
            tick("rnd_reset_hold");
            reset = 1'b1;
         end
         tick("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/menu_controller.md
Name: menu_controller

Overview:
- Sequencing FSM for the configuration menu: walks the user through mode, BPM, tone, song and error-limit selection, one at a time.
- Drives menu_sel and load_initial into the menu datapath and gates the arrow keys through nav_enable.
- Emits arduino_update whenever the displayed item changes.
- Signals config_done to the game FSM. Returns to idle on inactivity timeout.

Parameters:
- TIMEOUT_CYCLES, 50_000_000 — idle cycles in any select state before abandoning the menu; must be >= 2.
- CNT_W, $clog2(TIMEOUT_CYCLES) — width of the inactivity counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; its rising edge opens the menu.
- enter_pressed  in  1  raw level of the confirm key.
- back_pressed  in  1  raw level of the back key.
- arrow_pressed  in  1  OR of the left/right arrow levels; used for activity detection only.
- skip_musica  in  1  high when the selected mode has no song choice (free-play).
- restart  in  1  level; its rising edge returns the FSM to IDLE from DONE.
- menu_sel  out  3  000 MODO, 001 BPM, 010 TOM, 011 MUSICA, 100 ERRO.
- load_initial  out  1  one-cycle pulse that loads the one-hot defaults into the menu.
- nav_enable  out  1  high in select states; the top level ANDs it with the arrow levels.
- arduino_update  out  1  one-cycle strobe: display must resample arduino_out.
- config_done  out  1  level, high only in DONE.
- timeout  out  1  one-cycle pulse when the inactivity limit expires.

Behaviour:
- Input edges
  - Each of the five level inputs has its own rising-edge detector: a registered previous sample, pulse = level & ~prev.
  - Every transition occurs on the same clock edge at which the pulse is high: one transition per press, no auto-repeat.
- States: IDLE, LOAD, S_MODO, S_BPM, S_TOM, S_MUSICA, S_ERRO, DONE.
- Transitions (back has priority over enter when both pulse in the same cycle):
  - IDLE: start -> LOAD.
  - LOAD -> S_MODO unconditionally after exactly 1 cycle.
  - S_MODO: enter -> S_BPM; back -> IDLE.
  - S_BPM: enter -> S_TOM; back -> S_MODO.
  - S_TOM: enter -> S_ERRO if skip_musica=1, else S_MUSICA; back -> S_BPM.
  - S_MUSICA: enter -> S_ERRO; back -> S_TOM.
  - S_ERRO: enter -> DONE; back -> S_TOM if skip_musica=1, else S_MUSICA.
  - DONE: restart -> IDLE; back -> S_ERRO; enter is ignored.
  - skip_musica is sampled only on the edge where the transition is taken.
- Outputs
  - Moore decode of the registered state.
  - menu_sel = code of the current select state; 000 in IDLE, LOAD and DONE.
  - load_initial = 1 only in LOAD.
  - nav_enable = 1 in S_* states only.
- arduino_update
  - Registered pulse asserted the cycle after entering any S_* state.
  - Also asserted the cycle after any arrow pulse while nav_enable=1.
  - Never asserted in IDLE, LOAD or DONE.
- Inactivity counter
  - Counts while the state is S_*.
  - Cleared on any enter, back or arrow pulse, and on every state change.
  - When it reaches TIMEOUT_CYCLES-1 in an S_* state: next edge goes to IDLE, timeout=1 for that cycle, counter clears.
  - Held at 0 outside S_* states.
  - An enter/back pulse on the expiry cycle takes priority; the counter clears and no timeout is issued.
- Reset
  - Asserting reset at any time forces IDLE immediately and asynchronously.
  - All outputs go to 0, counter to 0, edge-detector registers to 0.
  - A key held during reset release produces one pulse on the first edge.
- start pulses outside IDLE and restart pulses outside DONE are ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (3 bits);
  - MENU_SEL_MODO/BPM/TOM/MUSICA/ERRO codes, shared with the top level that decodes menu_sel.
- Sub-module: reuse the existing edge_detector, five instances, with reset tied to the inverted active-low reset.
- Inactivity counter and arduino_update register live inline.

Test Plan:
- Reset low, then release; pulse start -> load_initial=1 for exactly 1 cycle. Next cycle menu_sel=000, nav_enable=1; one cycle later arduino_update=1.
- start, then enter x5 with skip_musica=0 -> menu_sel sequence 000,001,010,011,100, then config_done=1 with menu_sel=000.
- skip_musica=1: in S_TOM press enter -> menu_sel 010→100 (011 never appears). Back from S_ERRO -> 010.
- Enter and back pulsed in the same cycle in S_BPM -> state S_MODO (menu_sel=000), not S_TOM.
- TIMEOUT_CYCLES=8, S_BPM, no input -> timeout=1 on the 8th cycle, then IDLE. An arrow at cycle 5 delays expiry by 5 cycles and gives arduino_update=1 the cycle after the arrow.
- Reset asserted mid-S_MUSICA -> all outputs 0 asynchronously. After release, enter held high -> ignored in IDLE; state stays IDLE.
